corefifo_wr_status: RTL and testbench

// - Write-side pointer and flag generator of the async FIFO, in the write clock domain.
// - Owns the binary and Gray write pointers.
// - Synchronises the read-domain Gray pointer and converts it to binary (MSB copy, XOR cascade).
// - Produces full, almost-full, fill count and the RAM write strobe/address.
// - Its registered Gray write pointer feeds the read-side synchroniser.

---
 rtl/corefifo_pkg.sv | 32 +++
 rtl/corefifo_wr_status_if.sv | 28 ++
 rtl/corefifo_ptr_sync.sv | 40 ++++
 rtl/corefifo_wr_status.sv | 104 ++++++++++
 tb/tb_corefifo_wr_status.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/corefifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read status blocks.
// Latency: pure functions, no state.
// Backpressure: none; used by blocks that gate their own writes/reads.
package corefifo_pkg;

  // Default address width and the matching FIFO depth.
  localparam int ADDRWIDTH_DFLT = 3;
  localparam int DEPTH          = 2 ** ADDRWIDTH_DFLT;

  // The helpers work on a zero-extended fixed-width vector.
  // This lets any pointer width up to PTR_MAXW share them.
  localparam int PTR_MAXW = 16;

  // Binary to Gray conversion: b ^ (b >> 1).
  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary conversion: copy the MSB, then XOR-cascade downwards.
  // The zero upper bits leave the cascade untouched, so narrower pointers
  // decode correctly.
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b = '0;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/corefifo_wr_status_if.sv
// Write-side status bus of the async FIFO: request, cross-domain pointers, flags.
// Latency: wires only.
// Backpressure: wen_ram is the accept qualifier; full/afull throttle the writer.
interface corefifo_wr_status_if #(
  parameter int ADDRWIDTH = 3
);
  logic                 we;
  logic [ADDRWIDTH:0]   rptr_gray_i;
  logic                 wen_ram;
  logic [ADDRWIDTH-1:0] waddr;
  logic [ADDRWIDTH:0]   wptr_gray_o;
  logic                 full;
  logic                 afull;
  logic [ADDRWIDTH:0]   wrcnt;
  logic                 overflow;

  // Status block side.
  modport slave (
    input  we, rptr_gray_i,
    output wen_ram, waddr, wptr_gray_o, full, afull, wrcnt, overflow
  );

  // Writer / read-domain side.
  modport master (
    output we, rptr_gray_i,
    input  wen_ram, waddr, wptr_gray_o, full, afull, wrcnt, overflow
  );
endinterface

// File: rtl/corefifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Latency: SYNC_STAGES clock edges from d to q.
// Backpressure: none; it samples every cycle.
module corefifo_ptr_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  // Each stage takes its predecessor; stage 0 takes the raw async input.
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser chain, cleared by the local-domain reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/corefifo_wr_status.sv
// Write-domain pointer/flag generator of the async FIFO (optional overflow via COREFIFO_WR_OVERFLOW_EN).
// Latency: write reflected in flags next edge; read-pointer moves visible after SYNC_STAGES+1 edges.
// Backpressure: writes are refused (wen_ram=0) while full or in reset; flags are pessimistic.
module corefifo_wr_status
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH    = ADDRWIDTH_DFLT,
  parameter int AFULL_THRESH = 6,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   wclk,
  input  logic                   wrst,
  corefifo_wr_status_if.slave    bus
);

  localparam int PW         = ADDRWIDTH + 1;
  localparam int FIFO_DEPTH = 1 << ADDRWIDTH;

  logic [PW-1:0]       wptr_bin_q,  wptr_bin_d;
  logic [PW-1:0]       wptr_gray_q, wptr_gray_d;
  logic [PW-1:0]       wrcnt_q,     wrcnt_d;
  logic                full_q,      full_d;
  logic                afull_q,     afull_d;
  logic [PW-1:0]       rptr_gray_s;
  logic [PW-1:0]       rptr_bin_s;
  logic [PTR_MAXW-1:0] rptr_bin_w;
  logic [PTR_MAXW-1:0] wgray_w;
  logic                wen;

  // Bring the read-domain Gray pointer into wclk; nothing else touches the raw input.
  corefifo_ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (wclk),
    .rst (wrst),
    .d   (bus.rptr_gray_i),
    .q   (rptr_gray_s)
  );

  // Accept decision, next pointers and next-state flags.
  // The current write and the freshest synchronised read pointer are
  // combined in one calculation.
  always_comb begin
    wen         = bus.we & ~full_q & ~wrst;
    rptr_bin_w  = gray2bin(PTR_MAXW'(rptr_gray_s));
    rptr_bin_s  = rptr_bin_w[PW-1:0];
    wptr_bin_d  = wptr_bin_q + PW'(wen);
    wgray_w     = bin2gray(PTR_MAXW'(wptr_bin_d));
    wptr_gray_d = wgray_w[PW-1:0];
    wrcnt_d     = wptr_bin_d - rptr_bin_s;
    full_d      = (wrcnt_d == PW'(FIFO_DEPTH));
    afull_d     = (wrcnt_d >= PW'(AFULL_THRESH));
  end

  // Pointer and flag registers; reset discards any stored count.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      wrcnt_q     <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      wrcnt_q     <= wrcnt_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
    end
  end

`ifdef COREFIFO_WR_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // A write attempted against a full FIFO is flagged for one cycle.
  always_comb begin
    overflow_d = bus.we & full_q;
  end

  // Overflow pulse register.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  // The Gray pointer goes out straight from its flop so the read domain
  // never samples a combinational glitch.
  assign bus.wen_ram     = wen;
  assign bus.waddr       = wptr_bin_q[ADDRWIDTH-1:0];
  assign bus.wptr_gray_o = wptr_gray_q;
  assign bus.full        = full_q;
  assign bus.afull       = afull_q;
  assign bus.wrcnt       = wrcnt_q;

endmodule

// File: tb/tb_corefifo_wr_status.sv
// Directed plus randomized bench for the async FIFO write-status block.
// Reference model tracks total writes/reads as integers and a delayed read view.
// Every step drives inputs after an edge and samples 1 ns after the next edge.
module tb_corefifo_wr_status;
  import corefifo_pkg::*;

  localparam int AW  = 3;
  localparam int THR = 6;
  localparam int SS  = 2;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  corefifo_wr_status_if #(.ADDRWIDTH(AW)) bus ();

  corefifo_wr_status #(
    .ADDRWIDTH    (AW),
    .AFULL_THRESH (THR),
    .SYNC_STAGES  (SS)
  ) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: writes accepted so far (mod 16), the expected
  // registered outputs, and the read pointer values the DUT has yet to see.
  int m_wtot  = 0;
  int m_cnt   = 0;
  bit m_full  = 0;
  bit m_afull = 0;
  bit m_ovf   = 0;
  bit m_acc   = 0;
  int rq[$];

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational outputs, advance the model, check registers.
  task automatic step(input bit w, input int rbin, input bit rst);
    int seen;
    bus.we          = w;
    bus.rptr_gray_i = to_gray(rbin);
    wrst            = rst;
    #1;
    m_acc = w && !m_full && !rst;
    chk("wen_ram", 32'(bus.wen_ram), 32'(m_acc));
    chk("waddr", 32'(bus.waddr), m_wtot % DEPTH);
    @(posedge wclk);
    if (rst) begin
      m_wtot = 0; m_cnt = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      rq = {};
      repeat (SS) rq.push_back(0);
    end else begin
      seen = rq.pop_front();
      rq.push_back(rbin % 16);
`ifdef COREFIFO_WR_OVERFLOW_EN
      m_ovf = w && m_full;
`else
      m_ovf = 0;
`endif
      m_wtot  = (m_wtot + int'(m_acc)) % 16;
      m_cnt   = (m_wtot - seen + 16) % 16;
      m_full  = (m_cnt == DEPTH);
      m_afull = (m_cnt >= THR);
    end
    #1;
    chk("wrcnt", 32'(bus.wrcnt), m_cnt);
    chk("full", 32'(bus.full), 32'(m_full));
    chk("afull", 32'(bus.afull), 32'(m_afull));
    chk("wptr_gray", 32'(bus.wptr_gray_o), 32'(to_gray(m_wtot)));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  initial begin
    logic [3:0] prev_g;
    bit         rolled;
    int         rtot;
    int         wlim;

    bus.we = 1'b0;
    bus.rptr_gray_i = '0;
    repeat (SS) rq.push_back(0);

    // Reset held 3 cycles with write requested: nothing is accepted.
    repeat (3) step(1, 0, 1);
    chk("rst_wrcnt", 32'(bus.wrcnt), 0);
    chk("rst_full", 32'(bus.full), 0);

    // Fill from empty with the read pointer parked at 0.
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      chk("fill_cnt", 32'(bus.wrcnt), i + 1);
      chk("fill_afull", 32'(bus.afull), (i + 1 >= 6) ? 1 : 0);
    end
    chk("fill_full", 32'(bus.full), 1);

    // Two rejected writes while full; pointer must hold at 8.
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0);
      chk("ovf_hold", 32'(bus.wptr_gray_o), 32'(to_gray(8)));
`ifdef COREFIFO_WR_OVERFLOW_EN
      chk("ovf_pulse", 32'(bus.overflow), 1);
`else
      chk("ovf_tied", 32'(bus.overflow), 0);
`endif
    end

    // Read pointer moves to 1: full must drop on exactly the third edge.
    step(0, 1, 0);
    chk("sync_e1_full", 32'(bus.full), 1);
    step(0, 1, 0);
    chk("sync_e2_full", 32'(bus.full), 1);
    step(0, 1, 0);
    chk("sync_e3_full", 32'(bus.full), 0);
    chk("sync_e3_cnt", 32'(bus.wrcnt), 7);

    // Wrap: 40 writes with the read side trailing so the count settles at 2.
    step(0, 0, 1);
    prev_g = bus.wptr_gray_o;
    rolled = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, (m_wtot + 1) % 16, 0);
      chk("wrap_1bit", 32'($countones(bus.wptr_gray_o ^ prev_g)), 1);
      if (prev_g == to_gray(15) && bus.wptr_gray_o == 4'b0000) rolled = 1;
      prev_g = bus.wptr_gray_o;
      if (i >= 1) chk("wrap_cnt2", 32'(bus.wrcnt), 2);
      chk("wrap_nofull", 32'(bus.full), 0);
    end
    chk("wrap_rollover", 32'(rolled), 1);

    // Mid-stream reset at a count of 5.
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("mid_cnt5", 32'(bus.wrcnt), 5);
    step(1, 0, 1);
    chk("mid_rst_cnt", 32'(bus.wrcnt), 0);
    chk("mid_rst_gray", 32'(bus.wptr_gray_o), 0);
    chk("mid_rst_afull", 32'(bus.afull), 0);

    // Randomized traffic: reads never pass writes the writer has accepted.
    rtot = 0;
    for (int i = 0; i < 300; i++) begin
      wlim = m_wtot;
      if (((wlim - rtot + 16) % 16) != 0 && ($urandom_range(0, 99) < 45)) rtot = (rtot + 1) % 16;
      step($urandom_range(0, 99) < 60, rtot, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
